// File: rtl/multiplexador_fila.sv
// Bus source multiplexer feeding a 2-entry valid/ready skid buffer.
// Each accepted selection captures {data, sel}; out-of-range selects raise a sticky error.
module multiplexador_fila #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS + 2)
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REGS*DATA_W-1:0] regs_in,
  input  logic [DATA_W-1:0]          imm,
  input  logic [DATA_W-1:0]          R,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          saida,
  output logic [SEL_W-1:0]           saida_src,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sel_err,
  input  logic                       err_clr
);

  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(NUM_REGS + 1);

  logic [DATA_W-1:0] sel_data;
  logic              sel_bad;

  logic [DATA_W-1:0] mem_data [2];
  logic [SEL_W-1:0]  mem_src  [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;

  logic push;
  logic pop;

  // Source decode: anything outside the map drives zero and flags an error.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = regs_in[k*DATA_W +: DATA_W];
        sel_bad  = 1'b0;
      end
    end
    if (sel == SEL_IMM) begin
      sel_data = imm;
      sel_bad  = 1'b0;
    end
    if (sel == SEL_ALU) begin
      sel_data = R;
      sel_bad  = 1'b0;
    end
  end

  // in_ready depends on count only, so the consumer's out_ready never reaches the producer combinationally.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign saida     = out_valid ? mem_data[head] : '0;
  assign saida_src = out_valid ? mem_src[head]  : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the two storage entries are reset explicitly so the bus reads zero after reset, not stale data.
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_src[0]  <= '0;
      mem_src[1]  <= '0;
    end else if (push) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      mem_data[tail] <= sel_data;
      mem_src[tail]  <= sel;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Setting wins over clearing so an error accepted alongside err_clr is not lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sel_err <= 1'b0;
    end else if (push && sel_bad) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multiplexador_fila.sv
// Scoreboard bench for multiplexador_fila: entries queued on accept, compared at the buffer head.
module tb_multiplexador_fila;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = $clog2(NUM_REGS + 2);

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  s;
  } entry_t;

  logic                       clock = 1'b0;
  logic                       resetn = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] regs_in = '0;
  logic [DATA_W-1:0]          imm = '0;
  logic [DATA_W-1:0]          R = '0;
  logic [SEL_W-1:0]           sel = '0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [DATA_W-1:0]          saida;
  logic [SEL_W-1:0]           saida_src;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic                       sel_err;
  logic                       err_clr = 1'b0;

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];
  logic   m_err = 1'b0;

  multiplexador_fila #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .resetn(resetn), .regs_in(regs_in), .imm(imm), .R(R),
    .sel(sel), .in_valid(in_valid), .in_ready(in_ready), .saida(saida),
    .saida_src(saida_src), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t model(input logic [SEL_W-1:0] s);
    entry_t e;
    e.s = s;
    if (s < SEL_W'(NUM_REGS))       e.d = regs_in[int'(s)*DATA_W +: DATA_W];
    else if (s == SEL_W'(NUM_REGS)) e.d = imm;
    else if (s == SEL_W'(NUM_REGS+1)) e.d = R;
    else                            e.d = '0;
    return e;
  endfunction

  // Monitor: compare state against the model, then advance the model for the coming edge.
  always @(negedge clock) begin
    if (resetn) begin
      check("in_ready", in_ready, q.size() != 2);
      check("out_valid", out_valid, q.size() != 0);
      check("sel_err", sel_err, m_err);
      if (q.size() > 0) begin
        check("saida", saida, q[0].d);
        check("saida_src", saida_src, q[0].s);
      end else begin
        check("saida_idle", saida, 0);
        check("src_idle", saida_src, 0);
      end
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && q.size() < 2 + (out_ready ? 1 : 0) && in_ready) begin
        q.push_back(model(sel));
        if (sel > SEL_W'(NUM_REGS+1)) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end else if (err_clr) begin
        m_err = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic rdy, input logic clr);
    in_valid  = v;
    sel       = s;
    out_ready = rdy;
    err_clr   = clr;
    step();
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    err_clr = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) regs_in[k*DATA_W +: DATA_W] = 16'h0100 + 16'(k);
    regs_in[0*DATA_W +: DATA_W] = 16'h0001;
    regs_in[1*DATA_W +: DATA_W] = 16'h0011;
    regs_in[2*DATA_W +: DATA_W] = 16'h0022;
    regs_in[3*DATA_W +: DATA_W] = 16'h00A3;
    imm = 16'h1234;
    R   = 16'hBEEF;

    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_saida", saida, 0);
    check("rst_sel_err", sel_err, 0);
    resetn = 1'b1;
    step();

    // Source map with a free-running consumer.
    drive(1, 4'd3, 1, 0);
    check("map_r3", saida, 16'h00A3);
    check("map_r3_src", saida_src, 3);
    drive(1, 4'd8, 1, 0);
    check("map_imm", saida, 16'h1234);
    drive(1, 4'd9, 1, 0);
    check("map_alu", saida, 16'hBEEF);
    drive(0, 4'd0, 1, 0);
    drive(0, 4'd0, 1, 0);

    // Stall: fill both entries, third offer must be blocked.
    drive(1, 4'd1, 0, 0);
    drive(1, 4'd2, 0, 0);
    check("stall_full", in_ready, 0);
    drive(1, 4'd3, 0, 0);
    drive(1, 4'd3, 0, 0);
    check("stall_head", saida, 16'h0011);
    drive(0, 4'd0, 1, 0);
    check("stall_second", saida, 16'h0022);
    drain();

    // Simultaneous push and pop with one entry held.
    drive(1, 4'd1, 0, 0);
    drive(1, 4'd2, 1, 0);
    drive(0, 4'd0, 0, 0);
    check("simul_data", saida, 16'h0022);
    check("simul_count1", {in_ready, out_valid}, 2'b11);
    drain();

    // Sticky error: set wins over a same-cycle clear.
    drive(1, 4'd10, 1, 0);
    check("err_data", saida, 0);
    check("err_src", saida_src, 10);
    check("err_set", sel_err, 1);
    drive(0, 4'd0, 1, 0);
    check("err_held", sel_err, 1);
    drive(1, 4'd15, 1, 1);
    check("err_set_wins", sel_err, 1);
    drive(0, 4'd0, 1, 1);
    check("err_cleared", sel_err, 0);
    drive(0, 4'd0, 1, 0);

    // Sample-hold: source change after acceptance does not reach the stored entry.
    drive(1, 4'd0, 0, 0);
    regs_in[0*DATA_W +: DATA_W] = 16'hFFFF;
    drive(0, 4'd0, 0, 0);
    drive(0, 4'd0, 0, 0);
    check("hold", saida, 16'h0001);
    drain();
    regs_in[0*DATA_W +: DATA_W] = 16'h0001;

    // Asynchronous reset while the buffer is full and the error flag is set.
    drive(1, 4'd11, 0, 0);
    drive(1, 4'd2, 0, 0);
    resetn = 1'b0;
    #1;
    check("amid_in_ready", in_ready, 1);
    check("amid_out_valid", out_valid, 0);
    check("amid_saida", saida, 0);
    check("amid_sel_err", sel_err, 0);
    q.delete();
    m_err = 1'b0;
    in_valid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    drive(1, 4'd9, 1, 0);
    check("post_rst", saida, 16'hBEEF);
    drain();

    // Random traffic checked by the monitor.
    for (int i = 0; i < 300; i++) begin
      regs_in[($urandom_range(0, NUM_REGS-1))*DATA_W +: DATA_W] = 16'($urandom);
      imm = 16'($urandom);
      R   = 16'($urandom);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
